// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared types, defaults and helpers for the motion-estimation engine
package me_pkg;

  localparam int DEF_PIX_W   = 8;
  localparam int DEF_BLK     = 16;
  localparam int DEF_RANGE   = 8;
  localparam int DEF_MEM_LAT = 1;

  // Wide enough for the candidate index of any practical search range
  localparam int TAG_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } me_state_e;

  // Metadata travelling alongside each outstanding memory read
  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [TAG_W-1:0] tag;
  } pipe_ent_t;

  // A full block of maximum differences fits without overflow
  function automatic int sad_width(input int pix_w, input int blk);
    return pix_w + 2 * $clog2(blk);
  endfunction

endpackage

// File: rtl/me_sad_acc.sv
// rtl/me_sad_acc.sv - absolute-difference accumulator with early-termination compare
module me_sad_acc
  import me_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int SAD_W = sad_width(DEF_PIX_W, DEF_BLK)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             first_i,
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic [SAD_W-1:0] best_i,
  output logic [SAD_W-1:0] sum_o,
  output logic             ge_o
);

  logic [PIX_W:0]   absd;
  logic [SAD_W-1:0] sum_q;
  logic [SAD_W-1:0] sum_d;

  // Running sum including the current pixel; first pixel restarts the sum
  always_comb begin
    absd  = (a_i >= b_i) ? ({1'b0, a_i} - {1'b0, b_i}) : ({1'b0, b_i} - {1'b0, a_i});
    sum_d = first_i ? SAD_W'(absd) : sum_q + SAD_W'(absd);
    ge_o  = (sum_d >= best_i);
  end

  // Accumulator register, advanced only for accepted pixels
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/me_search_engine.sv
// rtl/me_search_engine.sv - full-search block-matching motion-estimation engine
module me_search_engine
  import me_pkg::*;
#(
  parameter int PIX_W   = DEF_PIX_W,
  parameter int BLK     = DEF_BLK,
  parameter int RANGE   = DEF_RANGE,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          start_i,
  input  logic                                          et_en_i,
  output logic [$clog2(BLK*BLK)-1:0]                    ref_addr_o,
  input  logic [PIX_W-1:0]                              ref_data_i,
  output logic [$clog2((BLK+2*RANGE)*(BLK+2*RANGE))-1:0] srch_addr_o,
  input  logic [PIX_W-1:0]                              srch_data_i,
  output logic                                          busy_o,
  output logic                                          res_valid_o,
  input  logic                                          res_ready_i,
  output logic signed [$clog2(RANGE):0]                 mv_x_o,
  output logic signed [$clog2(RANGE):0]                 mv_y_o,
  output logic [sad_width(PIX_W, BLK)-1:0]              best_sad_o
);

  localparam int WIN   = BLK + 2*RANGE;
  localparam int SAD_W = sad_width(PIX_W, BLK);
  localparam int MV_W  = $clog2(RANGE) + 1;
  localparam int LB    = $clog2(BLK);
  localparam int LR    = $clog2(2*RANGE);
  localparam int PX_W  = 2*LB;
  localparam int CD_W  = 2*LR;
  localparam int SA_W  = $clog2(WIN*WIN);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(BLK*BLK-1);
  localparam logic [CD_W-1:0] CD_LAST = CD_W'(4*RANGE*RANGE-1);

  me_state_e state_q, state_d;
  logic [PX_W-1:0]  px_q, px_d;
  logic [CD_W-1:0]  cand_q, cand_d;
  logic             et_q, et_d;
  logic [SAD_W-1:0] best_q;
  logic [CD_W-1:0]  best_tag_q, acc_tag_q;
  logic             sad_done_q, skip_vld_q;
  logic [TAG_W-1:0] skip_tag_q;
  logic [SAD_W-1:0] res_sad_q;
  logic signed [MV_W-1:0] res_mvx_q, res_mvy_q;
  pipe_ent_t        pipe_q [MEM_LAT];
  pipe_ent_t        issue, head;
  logic             pipe_busy, live, abort, acc_en, acc_ge, start_run, ld_res;
  logic [SAD_W-1:0] acc_sum;

  // Pixel index is {y, x} and candidate index is {dy+RANGE, dx+RANGE}
  assign ref_addr_o  = px_q;
  assign srch_addr_o = SA_W'((int'(px_q[PX_W-1:LB]) + int'(cand_q[CD_W-1:LR])) * WIN
                             + int'(px_q[LB-1:0]) + int'(cand_q[LR-1:0]));

  assign issue = '{valid: (state_q == S_RUN), first: (px_q == '0),
                   last: (px_q == PX_LAST), tag: TAG_W'(cand_q)};
  assign head  = pipe_q[MEM_LAT-1];

  // Entries of an aborted candidate still in flight are dropped by tag
  assign live   = head.valid && !(skip_vld_q && (head.tag == skip_tag_q));
  assign abort  = live && et_q && acc_ge;
  assign acc_en = live && !abort;

  // Any outstanding read keeps the drain phase alive
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < MEM_LAT; i++) pipe_busy = pipe_busy | pipe_q[i].valid;
  end

  me_sad_acc #(.PIX_W(PIX_W), .SAD_W(SAD_W)) u_acc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (acc_en),
    .first_i (head.first),
    .a_i     (ref_data_i),
    .b_i     (srch_data_i),
    .best_i  (best_q),
    .sum_o   (acc_sum),
    .ge_o    (acc_ge)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state, scan counters and control strobes
  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    cand_d    = cand_q;
    et_d      = et_q;
    start_run = 1'b0;
    ld_res    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_RUN;
          px_d      = '0;
          cand_d    = '0;
          et_d      = et_en_i;
          start_run = 1'b1;
        end
      end
      S_RUN: begin
        if (abort && (head.tag == TAG_W'(cand_q))) begin
          if (cand_q == CD_LAST) state_d = S_DRAIN;
          else begin
            cand_d = cand_q + 1'b1;
            px_d   = '0;
          end
        end else if (px_q == PX_LAST) begin
          if (cand_q == CD_LAST) state_d = S_DRAIN;
          else begin
            cand_d = cand_q + 1'b1;
            px_d   = '0;
          end
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!pipe_busy && !sad_done_q) begin
          state_d = S_DONE;
          ld_res  = 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-latency shift register for pixel metadata
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Scan progress, best-candidate tracking and result capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      px_q       <= '0;
      cand_q     <= '0;
      et_q       <= 1'b0;
      best_q     <= '1;
      best_tag_q <= '0;
      acc_tag_q  <= '0;
      sad_done_q <= 1'b0;
      skip_vld_q <= 1'b0;
      skip_tag_q <= '0;
      res_sad_q  <= '0;
      res_mvx_q  <= '0;
      res_mvy_q  <= '0;
    end else begin
      px_q       <= px_d;
      cand_q     <= cand_d;
      et_q       <= et_d;
      sad_done_q <= acc_en && head.last;
      if (acc_en && head.last) acc_tag_q <= head.tag[CD_W-1:0];
      if (start_run) begin
        best_q     <= '1;
        best_tag_q <= '0;
        skip_vld_q <= 1'b0;
      end else begin
        // Strict less-than keeps the earliest candidate on ties
        if (sad_done_q && (acc_sum < best_q)) begin
          best_q     <= acc_sum;
          best_tag_q <= acc_tag_q;
        end
        if (abort) begin
          skip_vld_q <= 1'b1;
          skip_tag_q <= head.tag;
        end
      end
      if (ld_res) begin
        res_sad_q <= best_q;
        res_mvx_q <= $signed(best_tag_q[LR-1:0] - LR'(RANGE));
        res_mvy_q <= $signed(best_tag_q[CD_W-1:LR] - LR'(RANGE));
      end
    end
  end

  assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign res_valid_o = (state_q == S_DONE);
  assign mv_x_o      = res_mvx_q;
  assign mv_y_o      = res_mvy_q;
  assign best_sad_o  = res_sad_q;

endmodule

// File: tb/tb_me_search_engine.sv
// tb/tb_me_search_engine.sv - self-checking bench for me_search_engine
module tb_me_search_engine;

  localparam int PIX_W   = 8;
  localparam int BLK     = 4;
  localparam int RANGE   = 2;
  localparam int MEM_LAT = 2;
  localparam int WIN     = 8;
  localparam int FULL_LAT = 4*RANGE*RANGE*BLK*BLK + MEM_LAT + 2;

  typedef struct {
    logic signed [1:0] mvx;
    logic signed [1:0] mvy;
    logic [11:0]       sad;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, et_en, res_ready;
  logic [3:0]  ref_addr;
  logic [5:0]  srch_addr;
  logic [7:0]  ref_data, srch_data;
  logic        busy, res_valid;
  logic signed [1:0] mv_x, mv_y;
  logic [11:0] best_sad;

  logic [7:0] ref_mem  [16];
  logic [7:0] srch_mem [64];
  logic [7:0] rd_pipe  [MEM_LAT];
  logic [7:0] sd_pipe  [MEM_LAT];

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  me_search_engine #(.PIX_W(PIX_W), .BLK(BLK), .RANGE(RANGE), .MEM_LAT(MEM_LAT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .et_en_i     (et_en),
    .ref_addr_o  (ref_addr),
    .ref_data_i  (ref_data),
    .srch_addr_o (srch_addr),
    .srch_data_i (srch_data),
    .busy_o      (busy),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .mv_x_o      (mv_x),
    .mv_y_o      (mv_y),
    .best_sad_o  (best_sad)
  );

  always #5 clk = ~clk;

  // Synchronous memories with MEM_LAT cycles of read latency
  always @(posedge clk) begin
    rd_pipe[0] <= ref_mem[ref_addr];
    sd_pipe[0] <= srch_mem[srch_addr];
    for (int i = 1; i < MEM_LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      sd_pipe[i] <= sd_pipe[i-1];
    end
  end
  assign ref_data  = rd_pipe[MEM_LAT-1];
  assign srch_data = sd_pipe[MEM_LAT-1];

  initial begin
    #3000000;
    $display("FAIL watchdog sim_time=%0t limit=3000000", $time);
    $fatal(1);
  end

  // Reference block copied into the window at dx=+1, dy=-2; distinct filler elsewhere
  task automatic fill_scene1();
    for (int i = 0; i < 64; i++) srch_mem[i] = 8'(i*3 + 7);
    for (int y = 0; y < BLK; y++)
      for (int x = 0; x < BLK; x++) begin
        ref_mem[y*BLK + x]          = 8'((y*BLK + x)*13 + 1);
        srch_mem[(y+0)*WIN + (x+3)] = 8'((y*BLK + x)*13 + 1);
      end
  endtask

  task automatic fill_const(input logic [7:0] r, input logic [7:0] s);
    for (int i = 0; i < 16; i++) ref_mem[i] = r;
    for (int i = 0; i < 64; i++) srch_mem[i] = s;
  endtask

  task automatic launch(input logic et);
    @(negedge clk);
    et_en = et;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    et_en = 1'b0;
  endtask

  task automatic wait_result(output int cycles, output bit timed_out);
    cycles = 0;
    while (!res_valid && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    timed_out = !res_valid;
  endtask

  task automatic accept();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ref_addr, srch_addr} !== 10'd0) begin
      n_bad++; $display("FAIL reset_addr got ref=%0d srch=%0d want 0 0", ref_addr, srch_addr);
    end
    n_cmp++;
    if ({busy, res_valid, mv_x, mv_y, best_sad} !== 18'd0) begin
      n_bad++; $display("FAIL reset_out got busy=%0b vld=%0b mv=(%0d,%0d) sad=%0d want all 0",
                        busy, res_valid, mv_x, mv_y, best_sad);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, res_valid} !== 2'b00) begin
      n_bad++; $display("FAIL idle_after_reset got busy=%0b vld=%0b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_exact_match();
    exp_t e; int cyc; bit to;
    fill_scene1();
    sb_q.push_back('{mvx: 2'(1), mvy: 2'(-2), sad: 12'(0)});
    launch(1'b0);
    wait_result(cyc, to);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== FULL_LAT) begin
      n_bad++; $display("FAIL match_latency got %0d (timeout=%0b) want %0d", cyc, to, FULL_LAT);
    end
    n_cmp++;
    if ({mv_x, mv_y, best_sad} !== {e.mvx, e.mvy, e.sad}) begin
      n_bad++; $display("FAIL match_result got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                        mv_x, mv_y, best_sad, e.mvx, e.mvy, e.sad);
    end
    accept();
  endtask

  task automatic test_ties();
    exp_t e; int cyc; bit to;
    fill_const(8'd10, 8'd10);
    sb_q.push_back('{mvx: 2'(-2), mvy: 2'(-2), sad: 12'(0)});
    launch(1'b0);
    wait_result(cyc, to);
    e = sb_q.pop_front();
    n_cmp++;
    if (to || {mv_x, mv_y, best_sad} !== {e.mvx, e.mvy, e.sad}) begin
      n_bad++; $display("FAIL ties_result got (%0d,%0d,%0d) timeout=%0b want (%0d,%0d,%0d)",
                        mv_x, mv_y, best_sad, to, e.mvx, e.mvy, e.sad);
    end
    accept();
  endtask

  task automatic test_full_scale();
    exp_t e; int cyc; bit to;
    fill_const(8'd255, 8'd0);
    sb_q.push_back('{mvx: 2'(-2), mvy: 2'(-2), sad: 12'(16*255)});
    launch(1'b0);
    wait_result(cyc, to);
    e = sb_q.pop_front();
    n_cmp++;
    if (to || {mv_x, mv_y, best_sad} !== {e.mvx, e.mvy, e.sad}) begin
      n_bad++; $display("FAIL full_scale got (%0d,%0d,%0d) timeout=%0b want (%0d,%0d,%0d)",
                        mv_x, mv_y, best_sad, to, e.mvx, e.mvy, e.sad);
    end
    accept();
  endtask

  task automatic test_early_term();
    exp_t e; int cyc; bit to;
    fill_scene1();
    sb_q.push_back('{mvx: 2'(1), mvy: 2'(-2), sad: 12'(0)});
    launch(1'b1);
    wait_result(cyc, to);
    e = sb_q.pop_front();
    n_cmp++;
    if (to || cyc >= FULL_LAT) begin
      n_bad++; $display("FAIL et_latency got %0d (timeout=%0b) want < %0d", cyc, to, FULL_LAT);
    end
    n_cmp++;
    if ({mv_x, mv_y, best_sad} !== {e.mvx, e.mvy, e.sad}) begin
      n_bad++; $display("FAIL et_result got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                        mv_x, mv_y, best_sad, e.mvx, e.mvy, e.sad);
    end
    accept();
  endtask

  task automatic test_et_ties();
    exp_t e; int cyc; bit to;
    fill_const(8'd255, 8'd0);
    sb_q.push_back('{mvx: 2'(-2), mvy: 2'(-2), sad: 12'(4080)});
    launch(1'b1);
    wait_result(cyc, to);
    e = sb_q.pop_front();
    n_cmp++;
    if (to || {mv_x, mv_y, best_sad} !== {e.mvx, e.mvy, e.sad}) begin
      n_bad++; $display("FAIL et_ties got (%0d,%0d,%0d) timeout=%0b want (%0d,%0d,%0d)",
                        mv_x, mv_y, best_sad, to, e.mvx, e.mvy, e.sad);
    end
    accept();
  endtask

  task automatic test_back_pressure();
    exp_t e; int cyc; bit to;
    fill_scene1();
    sb_q.push_back('{mvx: 2'(1), mvy: 2'(-2), sad: 12'(0)});
    launch(1'b0);
    wait_result(cyc, to);
    e = sb_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i % 3 == 0);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({res_valid, busy, mv_x, mv_y, best_sad} !== {1'b1, 1'b0, e.mvx, e.mvy, e.sad}) begin
        n_bad++; $display("FAIL hold_c%0d got vld=%0b busy=%0b (%0d,%0d,%0d) want 1 0 (%0d,%0d,%0d)",
                          i, res_valid, busy, mv_x, mv_y, best_sad, e.mvx, e.mvy, e.sad);
      end
    end
    @(negedge clk);
    start = 1'b0;
    accept();
    n_cmp++;
    if ({res_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL accept_idle got vld=%0b busy=%0b want 0 0", res_valid, busy);
    end
    fill_const(8'd10, 8'd10);
    sb_q.push_back('{mvx: 2'(-2), mvy: 2'(-2), sad: 12'(0)});
    launch(1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL restart_busy got %0b want 1", busy);
    end
    wait_result(cyc, to);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== FULL_LAT || {mv_x, mv_y, best_sad} !== {e.mvx, e.mvy, e.sad}) begin
      n_bad++; $display("FAIL restart_result got (%0d,%0d,%0d) lat=%0d want (%0d,%0d,%0d) lat=%0d",
                        mv_x, mv_y, best_sad, cyc, e.mvx, e.mvy, e.sad, FULL_LAT);
    end
    accept();
  endtask

  task automatic test_reset_mid_run();
    exp_t e; int cyc; bit to;
    fill_scene1();
    launch(1'b0);
    repeat (99) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ref_addr, srch_addr, busy, res_valid, mv_x, mv_y, best_sad} !== 28'd0) begin
      n_bad++; $display("FAIL async_reset got addr=%0d/%0d busy=%0b vld=%0b sad=%0d want all 0",
                        ref_addr, srch_addr, busy, res_valid, best_sad);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (res_valid !== 1'b0) begin
        n_bad++; $display("FAIL reset_hold_c%0d got vld=%0b want 0", i, res_valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (res_valid !== 1'b0) break;
    end
    n_cmp++;
    if ({res_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL no_partial got vld=%0b busy=%0b want 0 0", res_valid, busy);
    end
    sb_q.push_back('{mvx: 2'(1), mvy: 2'(-2), sad: 12'(0)});
    launch(1'b0);
    wait_result(cyc, to);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== FULL_LAT || {mv_x, mv_y, best_sad} !== {e.mvx, e.mvy, e.sad}) begin
      n_bad++; $display("FAIL rerun_result got (%0d,%0d,%0d) lat=%0d want (%0d,%0d,%0d) lat=%0d",
                        mv_x, mv_y, best_sad, cyc, e.mvx, e.mvy, e.sad, FULL_LAT);
    end
    accept();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    et_en     = 1'b0;
    res_ready = 1'b0;
    fill_const(8'd0, 8'd0);
    test_reset();
    test_exact_match();
    test_ties();
    test_full_scale();
    test_early_term();
    test_et_ties();
    test_back_pressure();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
